// File: rtl/sm1118_pkg.sv
// sm1118_pkg: shared types for the LED slot scheduler.
//   - color encodings as produced by the color detector
//   - scheduler FSM state enum
//   - slot index type (up to 3 slots)
package sm1118_pkg;

    typedef logic [1:0] color_t;

    localparam color_t COLOR_NONE  = 2'b00;
    localparam color_t COLOR_RED   = 2'b01;
    localparam color_t COLOR_BLUE  = 2'b10;
    localparam color_t COLOR_GREEN = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_HOLD  = 2'd2,
        ST_FULL  = 2'd3
    } state_e;

    typedef logic [1:0] slot_idx_t;

endpackage

// File: rtl/sm1118_color_debounce.sv
// sm1118_color_debounce: turns a stable run of valid color samples into a
// single one-cycle event, then stays disarmed until the detector reports
// a stable "no color" run.
//   clk, rst_n    : clock, async active-low reset
//   color_i       : raw detected color
//   color_valid_i : qualifies color_i; invalid cycles are ignored entirely
//   clear_i       : flush (re-arm, count 0); suppresses a same-cycle event
//   evt_valid_o   : one-cycle event strobe (combinational, pushed on this edge)
//   evt_color_o   : color carried by the event
module sm1118_color_debounce
    import sm1118_pkg::*;
#(
    parameter int DEBOUNCE = 4
) (
    input  logic   clk,
    input  logic   rst_n,
    input  color_t color_i,
    input  logic   color_valid_i,
    input  logic   clear_i,
    output logic   evt_valid_o,
    output color_t evt_color_o
);

    localparam int CW = $clog2(DEBOUNCE + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE);

    logic [CW-1:0] cnt_q, cnt_d;
    color_t        prev_q;
    logic          armed_q, armed_d;
    logic          evt;

    always_comb begin
        cnt_d   = cnt_q;
        armed_d = armed_q;
        evt     = 1'b0;
        if (color_valid_i) begin
            if (color_i == prev_q)
                cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
            else
                cnt_d = CW'(1);
            // Event fires only on the sample that completes the run, so a
            // saturated run cannot fire twice.
            if (cnt_d == CNT_MAX && cnt_q != CNT_MAX) begin
                if (color_i != COLOR_NONE) begin
                    if (armed_q) begin
                        evt     = 1'b1;
                        armed_d = 1'b0;
                    end
                end else begin
                    armed_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            prev_q  <= COLOR_NONE;
            armed_q <= 1'b1;
        end else if (clear_i) begin
            cnt_q   <= '0;
            prev_q  <= COLOR_NONE;
            armed_q <= 1'b1;
        end else begin
            cnt_q   <= cnt_d;
            armed_q <= armed_d;
            if (color_valid_i)
                prev_q <= color_i;
        end
    end

    assign evt_valid_o = evt & ~clear_i;
    assign evt_color_o = color_i;

endmodule

// File: rtl/sm1118_led_scheduler.sv
// sm1118_led_scheduler: queues debounced color events and writes them one
// at a time into consecutive LED slots, with a hold-off after each write.
//   clk, rst_n          : clock, async active-low reset
//   color_in/color_valid: raw detector result
//   clear               : blank slots and flush all state
//   led_we/led_sel/led_color : one-cycle slot write command
//   led_clr             : one-cycle "blank all slots" strobe
//   indicator           : last color issued
//   slots_used/full     : slot occupancy since last clear
//   overflow            : sticky, an event was dropped on a full queue
// FIFO_DEPTH must be a power of two and at least 2.
module sm1118_led_scheduler
    import sm1118_pkg::*;
#(
    parameter int SLOTS      = 3,
    parameter int DEBOUNCE   = 4,
    parameter int HOLDOFF    = 12000,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] color_in,
    input  logic       color_valid,
    input  logic       clear,
    output logic       led_we,
    output logic [1:0] led_sel,
    output logic [1:0] led_color,
    output logic       led_clr,
    output logic [1:0] indicator,
    output logic [1:0] slots_used,
    output logic       full,
    output logic       overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int HW = $clog2(HOLDOFF + 1);
    localparam slot_idx_t     SLOTS_N  = slot_idx_t'(SLOTS);
    localparam logic [HW-1:0] HOLD_END = HW'(HOLDOFF - 1);

    logic   evt_valid;
    color_t evt_color;

    sm1118_color_debounce #(.DEBOUNCE(DEBOUNCE)) u_deb (
        .clk          (clk),
        .rst_n        (rst_n),
        .color_i      (color_in),
        .color_valid_i(color_valid),
        .clear_i      (clear),
        .evt_valid_o  (evt_valid),
        .evt_color_o  (evt_color)
    );

    // Event queue: extra pointer bit distinguishes full from empty.
    color_t        mem_q [FIFO_DEPTH];
    logic [AW:0]   wr_q, rd_q;
    logic          f_empty, f_full, push, pop, drop;

    state_e        state_q, state_d;
    logic [HW-1:0] hold_q, hold_d;
    slot_idx_t     slots_q, slots_d;
    color_t        ind_q, ind_d;
    logic          ovf_q, clr_q;
    color_t        head;

    assign f_empty = (wr_q == rd_q);
    assign f_full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign head    = mem_q[rd_q[AW-1:0]];
    assign pop     = (state_q == ST_ISSUE);
    // A pop in the same cycle frees a slot, so a push onto a full queue is
    // still honoured then.
    assign push    = evt_valid && (!f_full || pop);
    assign drop    = evt_valid && f_full && !pop;

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        slots_d = slots_q;
        ind_d   = ind_q;
        case (state_q)
            ST_IDLE:
                if (!f_empty && slots_q < SLOTS_N) state_d = ST_ISSUE;
            ST_ISSUE: begin
                slots_d = slots_q + 1'b1;
                ind_d   = head;
                hold_d  = '0;
                state_d = ST_HOLD;
            end
            ST_HOLD:
                if (hold_q == HOLD_END)
                    state_d = (slots_q == SLOTS_N) ? ST_FULL : ST_IDLE;
                else
                    hold_d = hold_q + 1'b1;
            ST_FULL: state_d = ST_FULL;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            hold_q  <= '0;
            slots_q <= '0;
            ind_q   <= COLOR_NONE;
            ovf_q   <= 1'b0;
            wr_q    <= '0;
            rd_q    <= '0;
            clr_q   <= 1'b0;
        end else begin
            clr_q <= clear;
            if (clear) begin
                state_q <= ST_IDLE;
                hold_q  <= '0;
                slots_q <= '0;
                ind_q   <= COLOR_NONE;
                ovf_q   <= 1'b0;
                wr_q    <= '0;
                rd_q    <= '0;
            end else begin
                state_q <= state_d;
                hold_q  <= hold_d;
                slots_q <= slots_d;
                ind_q   <= ind_d;
                if (push) wr_q  <= wr_q + 1'b1;
                if (pop)  rd_q  <= rd_q + 1'b1;
                if (drop) ovf_q <= 1'b1;
            end
        end
    end

    // Storage needs no reset; occupancy lives in the pointers.
    always_ff @(posedge clk) begin
        if (push && !clear)
            mem_q[wr_q[AW-1:0]] <= evt_color;
    end

    assign led_we     = (state_q == ST_ISSUE);
    assign led_sel    = led_we ? slots_q : 2'b00;
    assign led_color  = led_we ? head : COLOR_NONE;
    assign led_clr    = clr_q;
    assign indicator  = ind_q;
    assign slots_used = slots_q;
    assign full       = (slots_q == SLOTS_N);
    assign overflow   = ovf_q;

endmodule
